cpu_trace_streamer: RTL and testbench
=====================================

Name: cpu_trace_streamer

Overview:
Hardware counterpart to the simulation state dump of the single-cycle CPU. On every committed instruction it captures PC and instruction word, stalls the CPU, walks all 32 registers through a read-only regfile debug port, and emits one 35-word frame on a valid/ready stream. A host-side sink or logic analyser consumes the stream. The block sits beside the CPU core and drives the core's stall input.

Parameters:
DATA_W, 32, width of PC, instruction, register and stream words
NREG, 32, number of architectural registers walked per frame
ADDR_W, 5, regfile debug address width (clog2 NREG)
HDR_TAG, 16'hA5A5, upper half of the frame header word

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous reset, active-high
ena  in  1  trace enable; sampled only in IDLE
commit_valid  in  1  CPU retires an instruction at this rising edge
commit_pc  in  DATA_W  PC of the retiring instruction
commit_instr  in  DATA_W  instruction word of the retiring instruction
stall_req  out  1  CPU must hold PC and regfile while high
dbg_raddr  out  ADDR_W  regfile debug read address
dbg_rdata  in  DATA_W  combinational regfile read data for dbg_raddr
tx_valid  out  1  stream word valid
tx_ready  in  1  sink accepts word
tx_data  out  DATA_W  stream word
tx_last  out  1  marks final word of frame (reg NREG-1)
busy  out  1  high whenever state != IDLE
overflow  out  1  sticky: commit seen while a frame was in progress
frame_cnt  out  16  count of completed frames

Behaviour:
- Reset (async, immediate): state=IDLE, tx_valid=0, tx_last=0, tx_data=0, stall_req=0, busy=0, dbg_raddr=0, overflow=0, frame_cnt=0, captured PC/instr=0.
- States: IDLE, HDR, PC, INSTR, REGS.
- IDLE: on a rising edge with ena=1 and commit_valid=1, latch commit_pc/commit_instr and go to HDR. Otherwise stay in IDLE.
- stall_req = busy, registered-state decode. It rises the cycle after the capture edge, so the captured instruction's writeback has completed and no further instruction commits.
- Word transfer occurs on a rising edge with tx_valid=1 and tx_ready=1. tx_valid=1 in every non-IDLE state.
- While tx_ready=0, tx_data, tx_last and dbg_raddr hold stable.
- HDR: tx_data = {HDR_TAG, frame_cnt}. Go to PC on transfer.
- PC: tx_data = latched pc. Go to INSTR on transfer.
- INSTR: tx_data = latched instr. On transfer, go to REGS with dbg_raddr=0.
- REGS: tx_data = dbg_rdata (combinational pass-through; stable because the CPU is stalled). On transfer, dbg_raddr increments. tx_last = (dbg_raddr == NREG-1).
- On the final transfer: return to IDLE, frame_cnt+1 (wraps 16'hFFFF -> 0), dbg_raddr -> 0.
- Minimum frame length is 35 cycles with tx_ready held high. The earliest next capture is the edge after the return to IDLE.
- Register 0 is streamed as read (expected 0). The block does not force it.
- commit_valid=1 while busy: word ignored, overflow set (sticky until rst). Frame continues unaffected.
- ena falling mid-frame: the current frame completes; no new capture.
- rst mid-frame: immediate abort per the reset values above. No partial tx_last is ever emitted.
- commit_valid with ena=0: no capture, no overflow.

Decomposition:
- Shared package holds:
  - the state enum (IDLE, HDR, PC, INSTR, REGS);
  - the HDR_TAG constant;
  - FRAME_WORDS = NREG + 3;
  - the frame word-index constants, reused by the host-side frame checker.
- No sub-module needed. An optional small register-walk counter, trace_reg_walker (dbg_raddr counter plus last decode), is acceptable.

Test Plan:
- Single commit, pc=32'h00400000, instr=32'h2008000A, regs loaded r[i]=i*4, tx_ready=1 -> 35 words: A5A50000, 00400000, 2008000A, 0, 4, ..., 7C. tx_last only on word 35. stall_req high 35 cycles. frame_cnt=1.
- Backpressure: tx_ready toggled 1-0-1-0 through a frame -> each word is held until accepted, data stable during stall, frame content identical, length 70 cycles.
- Commit during a frame (commit_valid pulse at word 10) -> overflow=1 and stays 1. Frame completes unchanged. No second frame starts.
- ena=0 with commit_valid=1 -> tx_valid, stall_req and busy remain 0. ena dropped at word 5 -> the frame still completes all 35 words.
- rst asserted at word 20 -> next sample shows tx_valid=0, stall_req=0, frame_cnt=0. The next commit yields header A5A50000.
- Preload frame_cnt path by running 65536 frames (or force) -> header A5A5FFFF, then next header A5A50000.

Source files
------------

// File: rtl/cpu_trace_streamer_pkg.sv
// Shared definitions for the CPU trace streamer and host-side frame checkers.
package cpu_trace_streamer_pkg;

  localparam int DATA_W = 32;
  localparam int NREG   = 32;
  localparam int ADDR_W = 5;

  localparam logic [15:0] HDR_TAG = 16'hA5A5;

  localparam int FRAME_WORDS = NREG + 3;

  // Word positions inside one frame
  localparam int WIDX_HDR   = 0;
  localparam int WIDX_PC    = 1;
  localparam int WIDX_INSTR = 2;
  localparam int WIDX_REG0  = 3;
  localparam int WIDX_LAST  = FRAME_WORDS - 1;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_HDR   = 3'd1,
    ST_PC    = 3'd2,
    ST_INSTR = 3'd3,
    ST_REGS  = 3'd4
  } trace_state_t;

  function automatic logic [DATA_W-1:0] hdr_word(input logic [15:0] cnt);
    return {HDR_TAG, cnt};
  endfunction

endpackage

// File: rtl/cpu_trace_streamer_walker.sv
// Register-walk counter: drives the regfile debug address and flags the
// final architectural register of the frame.
module trace_reg_walker
  import cpu_trace_streamer_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              inc,
  output logic [ADDR_W-1:0] addr,
  output logic              last
);

  // Address counter; clear has priority so a frame always restarts at r0
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr <= '0;
    end else if (clr) begin
      addr <= '0;
    end else if (inc) begin
      addr <= addr + 1'b1;
    end
  end

  assign last = (addr == ADDR_W'(NREG - 1));

endmodule

// File: rtl/cpu_trace_streamer.sv
// Captures PC/instruction on a committed instruction, stalls the core and
// streams a header, PC, instruction and all registers as one frame.
//
//  state | meaning
//  ------+-----------------------------------------------------------
//  IDLE  | waiting for a commit with ena=1; core runs freely
//  HDR   | presenting {HDR_TAG, frame_cnt}
//  PC    | presenting the captured PC
//  INSTR | presenting the captured instruction word
//  REGS  | presenting dbg_rdata for dbg_raddr = 0 .. NREG-1
module cpu_trace_streamer
  import cpu_trace_streamer_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              ena,
  input  logic              commit_valid,
  input  logic [DATA_W-1:0] commit_pc,
  input  logic [DATA_W-1:0] commit_instr,
  output logic              stall_req,
  output logic [ADDR_W-1:0] dbg_raddr,
  input  logic [DATA_W-1:0] dbg_rdata,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic [DATA_W-1:0] tx_data,
  output logic              tx_last,
  output logic              busy,
  output logic              overflow,
  output logic [15:0]       frame_cnt
);

  trace_state_t      state_q, state_d;
  logic [DATA_W-1:0] pc_q;
  logic [DATA_W-1:0] instr_q;
  logic [15:0]       frame_cnt_q;
  logic              overflow_q;

  logic              capture;
  logic              frame_done;
  logic              walk_clr;
  logic              walk_inc;
  logic              walk_last;

  trace_reg_walker u_walker (
    .clk  (clk),
    .rst  (rst),
    .clr  (walk_clr),
    .inc  (walk_inc),
    .addr (dbg_raddr),
    .last (walk_last)
  );

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and control decode; a word advances only when tx_ready is
  // high, since tx_valid is implied by every non-idle state
  always_comb begin
    state_d    = state_q;
    capture    = 1'b0;
    frame_done = 1'b0;
    walk_clr   = 1'b0;
    walk_inc   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (ena && commit_valid) begin
          capture = 1'b1;
          state_d = ST_HDR;
        end
      end
      ST_HDR: begin
        if (tx_ready) state_d = ST_PC;
      end
      ST_PC: begin
        if (tx_ready) state_d = ST_INSTR;
      end
      ST_INSTR: begin
        if (tx_ready) begin
          walk_clr = 1'b1;
          state_d  = ST_REGS;
        end
      end
      ST_REGS: begin
        if (tx_ready) begin
          if (walk_last) begin
            walk_clr   = 1'b1;
            frame_done = 1'b1;
            state_d    = ST_IDLE;
          end else begin
            walk_inc = 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Captured commit payload, held for the whole frame
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q    <= '0;
      instr_q <= '0;
    end else if (capture) begin
      pc_q    <= commit_pc;
      instr_q <= commit_instr;
    end
  end

  // Completed-frame counter, wraps naturally at 16 bits
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_cnt_q <= '0;
    end else if (frame_done) begin
      frame_cnt_q <= frame_cnt_q + 16'd1;
    end
  end

  // Sticky overflow: any commit arriving while a frame is in flight is lost
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overflow_q <= 1'b0;
    end else if (commit_valid && (state_q != ST_IDLE)) begin
      overflow_q <= 1'b1;
    end
  end

  // Stream word mux, decoded from registered state only
  always_comb begin
    tx_data = '0;
    case (state_q)
      ST_HDR:   tx_data = hdr_word(frame_cnt_q);
      ST_PC:    tx_data = pc_q;
      ST_INSTR: tx_data = instr_q;
      ST_REGS:  tx_data = dbg_rdata;
      default:  tx_data = '0;
    endcase
  end

  assign busy      = (state_q != ST_IDLE);
  assign stall_req = busy;
  assign tx_valid  = busy;
  assign tx_last   = (state_q == ST_REGS) && walk_last;
  assign overflow  = overflow_q;
  assign frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_cpu_trace_streamer.sv
// Self-checking bench for cpu_trace_streamer: directed table of frames,
// randomized frames against a queue-based frame model, and corner sequences.
module tb_cpu_trace_streamer;

  logic        clk = 1'b0;
  logic        rst;
  logic        ena;
  logic        commit_valid;
  logic [31:0] commit_pc;
  logic [31:0] commit_instr;
  logic        stall_req;
  logic [4:0]  dbg_raddr;
  logic [31:0] dbg_rdata;
  logic        tx_valid;
  logic        tx_ready;
  logic [31:0] tx_data;
  logic        tx_last;
  logic        busy;
  logic        overflow;
  logic [15:0] frame_cnt;

  logic [31:0] regs [32];

  int n_checks = 0;
  int n_fail   = 0;

  logic [15:0] exp_cnt;
  logic [31:0] got_words[$];
  logic        got_last[$];

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    int          mode;      // 0: ready high, 1: toggle starting low, 2: random
    int          commit_at; // word index for a stray commit pulse, -1 none
    int          drop_at;   // word index where ena drops, -1 none
    int          exp_len;   // expected busy cycles, 0 = do not check
    logic        exp_ovf;
  } vec_t;

  vec_t vecs [4];

  cpu_trace_streamer dut (
    .clk          (clk),
    .rst          (rst),
    .ena          (ena),
    .commit_valid (commit_valid),
    .commit_pc    (commit_pc),
    .commit_instr (commit_instr),
    .stall_req    (stall_req),
    .dbg_raddr    (dbg_raddr),
    .dbg_rdata    (dbg_rdata),
    .tx_valid     (tx_valid),
    .tx_ready     (tx_ready),
    .tx_data      (tx_data),
    .tx_last      (tx_last),
    .busy         (busy),
    .overflow     (overflow),
    .frame_cnt    (frame_cnt)
  );

  always #5 clk = ~clk;

  assign dbg_rdata = regs[dbg_raddr];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Runs one frame from capture to return-to-idle and compares it with the
  // frame the model derives from pc, instr, regs[] and exp_cnt.
  task automatic run_frame(input string tag, input logic [31:0] pc, input logic [31:0] instr,
                           input int mode, input int commit_at, input int drop_at,
                           output int cycles);
    logic [31:0] exp_words[$];
    logic [31:0] prev_data;
    logic        prev_last;
    logic [4:0]  prev_addr;
    logic        prev_stalled;
    logic        rdy;
    int          k;
    int          werr;
    int          lerr;
    int          serr;
    int          herr;
    int          idle_err;
    got_words.delete();
    got_last.delete();
    exp_words.push_back({16'hA5A5, exp_cnt});
    exp_words.push_back(pc);
    exp_words.push_back(instr);
    for (int i = 0; i < 32; i++) exp_words.push_back(regs[i]);

    @(negedge clk);
    ena          = 1'b1;
    commit_valid = 1'b1;
    commit_pc    = pc;
    commit_instr = instr;
    @(negedge clk);
    commit_valid = 1'b0;
    commit_pc    = $urandom;
    commit_instr = $urandom;

    k = 0; serr = 0; herr = 0; prev_stalled = 1'b0;
    prev_data = '0; prev_last = 1'b0; prev_addr = '0;
    while (busy === 1'b1 && k < 400) begin
      if (stall_req !== 1'b1 || tx_valid !== 1'b1) herr++;
      if (prev_stalled && (tx_data !== prev_data || tx_last !== prev_last || dbg_raddr !== prev_addr))
        serr++;
      commit_valid = (got_words.size() == commit_at && commit_at >= 0 && !commit_valid);
      if (got_words.size() == drop_at) ena = 1'b0;
      case (mode)
        0:       rdy = 1'b1;
        1:       rdy = (k % 2) == 1;
        default: rdy = ($urandom_range(0, 3) != 0);
      endcase
      tx_ready = rdy;
      if (rdy) begin
        got_words.push_back(tx_data);
        got_last.push_back(tx_last);
      end
      prev_stalled = !rdy;
      prev_data    = tx_data;
      prev_last    = tx_last;
      prev_addr    = dbg_raddr;
      @(negedge clk);
      k++;
    end
    commit_valid = 1'b0;
    tx_ready     = 1'b1;
    cycles       = k;
    check({tag, "_timeout"}, 32'(k >= 400), 32'd0);
    check({tag, "_nwords"}, 32'(got_words.size()), 32'd35);
    werr = 0;
    lerr = 0;
    for (int i = 0; i < 35; i++) begin
      if (i < got_words.size()) begin
        if (got_words[i] !== exp_words[i]) werr++;
        if (got_last[i] !== (i == 34)) lerr++;
      end
    end
    check({tag, "_word_mismatches"}, 32'(werr), 32'd0);
    check({tag, "_last_mismatches"}, 32'(lerr), 32'd0);
    check({tag, "_hold_unstable"}, 32'(serr), 32'd0);
    check({tag, "_stall_valid_low"}, 32'(herr), 32'd0);
    exp_cnt = exp_cnt + 16'd1;
    check({tag, "_frame_cnt"}, 32'(frame_cnt), 32'(exp_cnt));
    idle_err = 0;
    repeat (3) begin
      @(negedge clk);
      if (busy !== 1'b0 || tx_valid !== 1'b0 || stall_req !== 1'b0) idle_err++;
    end
    check({tag, "_stays_idle"}, 32'(idle_err), 32'd0);
  endtask

  task automatic ena_low_probe(input string tag);
    int err;
    err = 0;
    @(negedge clk);
    ena          = 1'b0;
    commit_valid = 1'b1;
    repeat (5) begin
      @(negedge clk);
      if (busy !== 1'b0 || tx_valid !== 1'b0 || stall_req !== 1'b0) err++;
    end
    commit_valid = 1'b0;
    check({tag, "_no_capture"}, 32'(err), 32'd0);
  endtask

  initial begin
    int cyc;
    logic ovf_before;
    rst          = 1'b1;
    ena          = 1'b0;
    commit_valid = 1'b0;
    commit_pc    = '0;
    commit_instr = '0;
    tx_ready     = 1'b1;
    exp_cnt      = '0;
    for (int i = 0; i < 32; i++) regs[i] = 32'(i * 4);

    vecs[0] = '{32'h0040_0000, 32'h2008_000A, 0, -1, -1, 35, 1'b0};
    vecs[1] = '{32'h0040_0004, 32'h8C09_0004, 1, -1, -1, 70, 1'b0};
    vecs[2] = '{32'h0040_0008, 32'h0109_5020, 0, 10, -1, 35, 1'b1};
    vecs[3] = '{32'h0040_000C, 32'hAC0A_0008, 0, -1,  5, 35, 1'b1};

    repeat (2) @(negedge clk);
    check("rst_tx_valid", 32'(tx_valid), 32'd0);
    check("rst_tx_last", 32'(tx_last), 32'd0);
    check("rst_tx_data", tx_data, 32'd0);
    check("rst_stall", 32'(stall_req), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_raddr", 32'(dbg_raddr), 32'd0);
    check("rst_overflow", 32'(overflow), 32'd0);
    check("rst_frame_cnt", 32'(frame_cnt), 32'd0);
    rst = 1'b0;

    ena_low_probe("ena0_pre");
    check("ena0_no_overflow", 32'(overflow), 32'd0);

    for (int v = 0; v < 4; v++) begin
      run_frame($sformatf("vec%0d", v), vecs[v].pc, vecs[v].instr, vecs[v].mode,
                vecs[v].commit_at, vecs[v].drop_at, cyc);
      if (vecs[v].exp_len != 0)
        check($sformatf("vec%0d_len", v), 32'(cyc), 32'(vecs[v].exp_len));
      check($sformatf("vec%0d_overflow", v), 32'(overflow), 32'(vecs[v].exp_ovf));
    end
    check("ena_dropped_stays_low", 32'(ena), 32'd0);
    ena_low_probe("ena0_post");

    for (int r = 0; r < 20; r++) begin
      for (int i = 0; i < 32; i++) regs[i] = (i == 0) ? 32'd0 : $urandom;
      run_frame($sformatf("rnd%0d", r), $urandom, $urandom, 2, -1, -1, cyc);
    end

    // Reset in the middle of a frame aborts it immediately
    ovf_before = overflow;
    check("pre_abort_overflow", 32'(ovf_before), 32'd1);
    for (int i = 0; i < 32; i++) regs[i] = 32'(i * 4);
    @(negedge clk);
    ena          = 1'b1;
    commit_valid = 1'b1;
    commit_pc    = 32'h0040_0100;
    commit_instr = 32'h2008_0001;
    @(negedge clk);
    commit_valid = 1'b0;
    tx_ready     = 1'b1;
    repeat (20) @(negedge clk);
    #1 rst = 1'b1;
    #1;
    check("abort_tx_valid", 32'(tx_valid), 32'd0);
    check("abort_stall", 32'(stall_req), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_tx_last", 32'(tx_last), 32'd0);
    check("abort_frame_cnt", 32'(frame_cnt), 32'd0);
    check("abort_overflow", 32'(overflow), 32'd0);
    @(negedge clk);
    rst     = 1'b0;
    exp_cnt = '0;
    run_frame("post_abort", 32'h0040_0200, 32'h2008_0002, 0, -1, -1, cyc);
    check("post_abort_header", got_words.size() > 0 ? got_words[0] : 32'hX, 32'hA5A5_0000);

    // Frame counter wrap
    @(negedge clk);
    force dut.frame_cnt_q = 16'hFFFF;
    @(negedge clk);
    release dut.frame_cnt_q;
    @(negedge clk);
    check("wrap_preload", 32'(frame_cnt), 32'h0000_FFFF);
    exp_cnt = 16'hFFFF;
    run_frame("wrap_a", 32'h0040_0300, 32'h2008_0003, 0, -1, -1, cyc);
    check("wrap_header_ffff", got_words.size() > 0 ? got_words[0] : 32'hX, 32'hA5A5_FFFF);
    check("wrap_cnt_zero", 32'(frame_cnt), 32'd0);
    run_frame("wrap_b", 32'h0040_0304, 32'h2008_0004, 0, -1, -1, cyc);
    check("wrap_header_0000", got_words.size() > 0 ? got_words[0] : 32'hX, 32'hA5A5_0000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
